lfsr_stream_cipher: RTL and testbench

Parametrised hardware successor to the Program 1 software encryptor. It streams a padded message frame through a W-bit LFSR XOR cipher and prepends a parity MSB to every byte. It also adds a decrypt mode that strips the cipher and counts parity errors. It sits between a data-memory reader and writer on valid/ready streams, so TopLevel can offload Programs 1/2 from the processor core.

---
 rtl/lfsr_cipher_pkg.sv | 18 +
 rtl/lfsr_step.sv | 27 ++
 rtl/lfsr_stream_cipher.sv | 159 +++++++++++++++
 tb/tb_lfsr_stream_cipher.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_cipher_pkg.sv
// Shared types and helpers for the LFSR stream cipher: FSM states,
// the standard tap-pattern table and a parity helper.
package lfsr_cipher_pkg;

    typedef enum logic [2:0] {IDLE, PRE, MSG, POST, DEC, DONE} state_t;

    localparam int NPTRN = 9;

    // Tap masks indexed by pattern number, for callers that map pt_no to Taps.
    localparam logic [6:0] LFSR_PTRN [NPTRN] = '{
        7'h60, 7'h48, 7'h78, 7'h72, 7'h6A, 7'h69, 7'h5C, 7'h7E, 7'h7B
    };

    function automatic logic parity(input logic [31:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/lfsr_step.sv
// Fibonacci-style LFSR: shifts left, feedback is the parity of the tapped bits.
// Holds its state until told to load a seed or advance one step.
module lfsr_step #(
    parameter int W = 7
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_adv,
    input  logic [W-1:0] i_taps,
    output logic [W-1:0] o_state,
    output logic [W-1:0] o_next
);

    logic [W-1:0] r_state;

    assign o_state = r_state;
    assign o_next  = {r_state[W-2:0], ^(r_state & i_taps)};

    always_ff @(posedge i_clk) begin
        if (i_reset)     r_state <= '0;
        else if (i_load) r_state <= i_load_val;
        else if (i_adv)  r_state <= o_next;
    end

endmodule

// File: rtl/lfsr_stream_cipher.sv
// Streams one FRAME of bytes through an LFSR XOR cipher: encrypt pads and
// adds a parity MSB, decrypt strips the keystream and counts parity errors.
module lfsr_stream_cipher
    import lfsr_cipher_pkg::*;
#(
    parameter int         W      = 7,
    parameter int         FRAME  = 64,
    parameter int         MAXMSG = 49,
    parameter logic [7:0] PAD    = 8'h20
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_start,
    input  logic         i_mode,
    input  logic [W-1:0] i_taps,
    input  logic [W-1:0] i_seed,
    input  logic [7:0]   i_pre_len,
    input  logic [7:0]   i_msg_len,
    input  logic         i_in_valid,
    output logic         o_in_ready,
    input  logic [W:0]   i_in_data,
    output logic         o_out_valid,
    input  logic         i_out_ready,
    output logic [W:0]   o_out_data,
    output logic         o_ack,
    output logic [6:0]   o_par_err_cnt
);

    localparam int           CW     = $clog2(FRAME + 1);
    localparam logic [W-1:0] PADW   = PAD[W-1:0];
    localparam logic [8:0]   FRAME9 = 9'(FRAME);
    localparam logic [8:0]   MAX9   = 9'(MAXMSG);

    // Encrypt phase that owns output byte n, given the latched phase boundaries.
    function automatic state_t enc_phase(input logic [CW-1:0] n, pe, me);
        if (n < pe) return PRE;
        if (n < me) return MSG;
        return POST;
    endfunction

    state_t        r_state, w_next_state;
    logic          r_start_d;
    logic [W-1:0]  r_taps;
    logic [CW-1:0] r_pre_end, r_msg_end, r_iss, r_acc;
    logic          r_out_valid;
    logic [W:0]    r_out_data;
    logic [6:0]    r_perr;

    logic [8:0]    w_pre9, w_m1, w_room9, w_msg9;
    logic [CW-1:0] w_pre_end, w_msg_end;
    logic [W-1:0]  w_seed, w_ks, w_lo, w_lfsr_q, w_lfsr_n;
    logic [W:0]    w_byte;
    logic          w_launch, w_pad_first, w_pad_phase, w_pass_phase;
    logic          w_slot, w_room, w_in_ready, w_issue, w_accept, w_last_acc;

    assign w_pre9    = ({1'b0, i_pre_len} >= FRAME9) ? FRAME9 : {1'b0, i_pre_len};
    assign w_m1      = ({1'b0, i_msg_len} > MAX9) ? MAX9 : {1'b0, i_msg_len};
    assign w_room9   = FRAME9 - w_pre9;
    assign w_msg9    = (w_m1 > w_room9) ? w_room9 : w_m1;
    assign w_pre_end = CW'(w_pre9);
    assign w_msg_end = CW'(w_pre9 + w_msg9);
    assign w_seed    = (i_seed == '0) ? W'(1) : i_seed;

    assign w_launch     = (r_state == IDLE) && r_start_d && !i_start;
    assign w_pad_first  = !i_mode && (enc_phase('0, w_pre_end, w_msg_end) != MSG);
    assign w_pad_phase  = (r_state == PRE) || (r_state == POST);
    assign w_pass_phase = (r_state == MSG) || (r_state == DEC);
    assign w_slot       = !r_out_valid || i_out_ready;
    assign w_room       = r_iss < CW'(FRAME);
    assign w_in_ready   = w_pass_phase && w_room && w_slot;
    assign w_issue      = w_room && w_slot && (w_pad_phase || (w_pass_phase && i_in_valid));
    assign w_accept     = r_out_valid && i_out_ready;
    assign w_last_acc   = w_accept && (r_acc == CW'(FRAME - 1));

    // The LFSR holds s_k for the oldest unaccepted byte; a byte issued while the
    // output register is still full is the next one, so it needs s_{k+1}.
    assign w_ks   = w_launch ? w_seed : (r_out_valid ? w_lfsr_n : w_lfsr_q);
    assign w_lo   = ((w_launch || w_pad_phase) ? PADW : i_in_data[W-1:0]) ^ w_ks;
    assign w_byte = (r_state == DEC) ? {1'b0, w_lo} : {parity(32'(w_lo)), w_lo};

    lfsr_step #(.W(W)) u_lfsr (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_load     (w_launch),
        .i_load_val (w_seed),
        .i_adv      (w_accept),
        .i_taps     (r_taps),
        .o_state    (w_lfsr_q),
        .o_next     (w_lfsr_n)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= IDLE;
        else         r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: if (w_launch)
                      w_next_state = i_mode ? DEC
                                   : enc_phase(w_pad_first ? CW'(1) : '0, w_pre_end, w_msg_end);
            PRE, MSG, POST: begin
                if (w_last_acc)   w_next_state = DONE;
                else if (w_issue) w_next_state = enc_phase(r_iss + CW'(1), r_pre_end, r_msg_end);
            end
            DEC:  if (w_last_acc) w_next_state = DONE;
            DONE: if (i_start)    w_next_state = IDLE;
            default:              w_next_state = IDLE;
        endcase
    end

    always_comb begin
        o_in_ready = w_in_ready;
        o_ack      = (r_state == DONE);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_start_d   <= 1'b0;
            r_taps      <= '0;
            r_pre_end   <= '0;
            r_msg_end   <= '0;
            r_iss       <= '0;
            r_acc       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_perr      <= '0;
        end else begin
            r_start_d <= i_start;
            if (w_launch) begin
                r_taps      <= i_taps;
                r_pre_end   <= w_pre_end;
                r_msg_end   <= w_msg_end;
                r_acc       <= '0;
                r_perr      <= '0;
                r_out_valid <= w_pad_first;
                r_iss       <= w_pad_first ? CW'(1) : '0;
                if (w_pad_first) r_out_data <= w_byte;
            end else begin
                if (w_accept) r_acc <= r_acc + CW'(1);
                if (w_issue) begin
                    r_out_valid <= 1'b1;
                    r_out_data  <= w_byte;
                    r_iss       <= r_iss + CW'(1);
                    if (r_state == DEC && parity(32'(i_in_data)) && r_perr != 7'd127)
                        r_perr <= r_perr + 7'd1;
                end else if (w_accept) begin
                    r_out_valid <= 1'b0;
                end
            end
        end
    end

    assign o_out_valid   = r_out_valid;
    assign o_out_data    = r_out_data;
    assign o_par_err_cnt = r_perr;

endmodule

// File: tb/tb_lfsr_stream_cipher.sv
// Directed bench for lfsr_stream_cipher: encrypt/decrypt frames against a
// small software model plus hand-computed bytes, stalls, clipping and reset.
module tb_lfsr_stream_cipher;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b1;
    logic       mode = 1'b0;
    logic [6:0] taps = 7'h69;
    logic [6:0] seed = 7'h01;
    logic [7:0] pre_len = 8'd0;
    logic [7:0] msg_len = 8'd0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       out_ready = 1'b0;
    logic       in_ready, out_valid, ack;
    logic [7:0] out_data;
    logic [6:0] perr;

    int checks = 0;
    int errors = 0;
    int cyc;

    logic [7:0] exp_out [64];
    logic [7:0] in_vec  [64];
    logic [7:0] cap     [64];
    logic [6:0] plain   [64];
    int         n_in;

    lfsr_stream_cipher dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_start       (start),
        .i_mode        (mode),
        .i_taps        (taps),
        .i_seed        (seed),
        .i_pre_len     (pre_len),
        .i_msg_len     (msg_len),
        .i_in_valid    (in_valid),
        .o_in_ready    (in_ready),
        .i_in_data     (in_data),
        .o_out_valid   (out_valid),
        .i_out_ready   (out_ready),
        .o_out_data    (out_data),
        .o_ack         (ack),
        .o_par_err_cnt (perr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Software model of the encryptor: padded plaintext and cipher bytes.
    task automatic build_enc(input logic [6:0] tp, input logic [6:0] sd,
                             input int pre, input int ml, input string msg);
        logic [6:0] s, c, lo;
        byte        b;
        int         pe, m;
        s  = (sd == 7'h00) ? 7'h01 : sd;
        pe = (pre > 64) ? 64 : pre;
        m  = (ml > 49) ? 49 : ml;
        if (m > 64 - pe) m = 64 - pe;
        for (int i = 0; i < 64; i++) begin
            if (i >= pe && i < pe + m) begin
                b = msg.getc(i - pe);
                c = b[6:0];
            end else begin
                c = 7'h20;
            end
            lo         = c ^ s;
            exp_out[i] = {^lo, lo};
            plain[i]   = c;
            in_vec[i]  = 8'h00;
            s          = {s[5:0], ^(s & tp)};
        end
        for (int k = 0; k < m; k++) in_vec[k] = {1'b0, plain[pe + k]};
        n_in = m;
    endtask

    // Feed the modelled ciphertext back; optionally corrupt bit 7 of bytes 3 and 40.
    task automatic build_dec(input bit flip);
        for (int i = 0; i < 64; i++) begin
            in_vec[i]  = exp_out[i];
            exp_out[i] = {1'b0, plain[i]};
        end
        if (flip) begin
            in_vec[3][7]  = ~in_vec[3][7];
            in_vec[40][7] = ~in_vec[40][7];
        end
        n_in = 64;
    endtask

    task automatic launch(input logic m, input logic [6:0] tp, input logic [6:0] sd,
                          input int pre, input int ml);
        mode = m; taps = tp; seed = sd;
        pre_len = 8'(pre); msg_len = 8'(ml);
        start = 1'b1;
        @(posedge clk); #1;
        chk("ack_cleared_by_start", 32'(ack), 32'd0);
        start = 1'b0;
        @(posedge clk); #1;
        chk("perr_cleared_on_launch", 32'(perr), 32'd0);
    endtask

    task automatic run_frame(input bit stall, input int limit, output int cycles);
        int         oi, ii;
        bit         hold;
        logic [7:0] held;
        oi = 0; ii = 0; cycles = 0; hold = 1'b0; held = 8'h00;
        while (oi < limit && cycles < 1000) begin
            out_ready = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
            in_valid  = (ii < 64) && (stall ? ($urandom_range(0, 2) != 0) : 1'b1);
            in_data   = (ii < 64) ? in_vec[ii] : 8'h00;
            #1;
            if (hold)
                chk("stall_hold", {23'd0, out_valid, out_data}, {23'd0, 1'b1, held});
            if (out_valid && out_ready) begin
                chk($sformatf("byte%0d", oi), 32'(out_data), 32'(exp_out[oi]));
                cap[oi] = out_data;
                oi++;
            end
            hold = out_valid && !out_ready;
            held = out_data;
            if (in_valid && in_ready) ii++;
            @(posedge clk); #1;
            cycles++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("frame_byte_count", 32'(oi), 32'(limit));
        if (limit == 64) begin
            chk("ack_after_frame", 32'(ack), 32'd1);
            chk("input_bytes_taken", 32'(ii), 32'(n_in));
            chk("in_ready_after_frame", 32'(in_ready), 32'd0);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_perr", 32'(perr), 32'd0);
        reset = 1'b0;

        // Pad-only frame, hand-computed leading bytes, one byte per cycle.
        build_enc(7'h69, 7'h01, 10, 0, "");
        launch(1'b0, 7'h69, 7'h01, 10, 0);
        chk("first_valid_after_launch", 32'(out_valid), 32'd1);
        run_frame(1'b0, 64, cyc);
        chk("pad_rate_cycles", 32'(cyc), 32'd64);
        chk("hand_b0", 32'(cap[0]), 32'h21);
        chk("hand_b1", 32'(cap[1]), 32'hA3);
        chk("hand_b2", 32'(cap[2]), 32'h27);

        // Zero seed behaves like seed 1.
        build_enc(7'h69, 7'h00, 10, 0, "");
        launch(1'b0, 7'h69, 7'h00, 10, 0);
        run_frame(1'b0, 64, cyc);
        chk("seed0_b0", 32'(cap[0]), 32'h21);
        chk("seed0_b1", 32'(cap[1]), 32'hA3);
        chk("seed0_b2", 32'(cap[2]), 32'h27);

        // Message frame under random stalls on both sides.
        build_enc(7'h69, 7'h01, 12, 12, "I love Wads!");
        launch(1'b0, 7'h69, 7'h01, 12, 12);
        run_frame(1'b1, 64, cyc);

        // Clean decrypt round trip at full rate.
        build_dec(1'b0);
        launch(1'b1, 7'h69, 7'h01, 0, 0);
        run_frame(1'b0, 64, cyc);
        chk("dec_rate_cycles", 32'(cyc), 32'd65);
        chk("dec_perr_clean", 32'(perr), 32'd0);

        // Decrypt with two corrupted parity bits, stalled.
        build_enc(7'h69, 7'h01, 12, 12, "I love Wads!");
        build_dec(1'b1);
        launch(1'b1, 7'h69, 7'h01, 0, 0);
        run_frame(1'b1, 64, cyc);
        chk("dec_perr_two", 32'(perr), 32'd2);

        // Message clipped to the 4 bytes left after 60 pad bytes.
        build_enc(7'h69, 7'h01, 60, 10, "0123456789");
        launch(1'b0, 7'h69, 7'h01, 60, 10);
        run_frame(1'b0, 64, cyc);

        // Reset after byte 20, then relaunch from s_0.
        build_enc(7'h69, 7'h01, 10, 0, "");
        launch(1'b0, 7'h69, 7'h01, 10, 0);
        run_frame(1'b0, 21, cyc);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        chk("midrst_ack", 32'(ack), 32'd0);
        chk("midrst_out_data", 32'(out_data), 32'd0);
        reset = 1'b0;
        launch(1'b0, 7'h69, 7'h01, 10, 0);
        chk("relaunch_b0", {23'd0, out_valid, out_data}, {23'd0, 1'b1, 8'h21});
        run_frame(1'b0, 64, cyc);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
